mantissa_add_sub_pipe: RTL

Parametrised, two-stage pipelined mantissa adder/subtractor for the FPU add path. It sits between exponent alignment and normalisation/rounding. It resolves the effective operation from the operand signs and the opcode, and produces the magnitude result, carry and result sign. It also pre-computes the leading-zero count and a zero flag so the normaliser needs no priority encoder. Full valid/ready handshake on both sides with backpressure, throughput one operation per cycle.

---
 rtl/mantissa_add_sub_pipe.sv | 128 ++++++++++++
 1 files changed

// File: rtl/mantissa_add_sub_pipe.sv
// Two-stage mantissa adder/subtractor for the FPU add path.
// Stage 1 resolves the operation; stage 2 adds leading-zero and zero flags.
module mantissa_add_sub_pipe #(
    parameter int MANTISSA_WIDTH = 23,
    parameter int LZC_W = $clog2(MANTISSA_WIDTH + 5),
    localparam int DW = MANTISSA_WIDTH + 4
) (
    input  logic             clk,
    input  logic             arst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [DW-1:0]    man_a,
    input  logic [DW-1:0]    man_b,
    input  logic             operation_select,
    input  logic             ma_sign,
    input  logic             mb_sign,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DW-1:0]    result,
    output logic             carry_out,
    output logic             result_sign,
    output logic [LZC_W-1:0] lzc,
    output logic             zero_result
);

    logic            s1_valid;
    logic [DW-1:0]   s1_r;
    logic            s1_c;
    logic            s1_sign;
    logic            s1_adv;
    logic            s2_adv;

    logic            eff_sub;
    logic            a_ge_b;
    logic [DW:0]     sum;
    logic [DW-1:0]   r_d;
    logic            c_d;
    logic            sign_d;

    logic            zero_d;
    logic [LZC_W-1:0] lzc_d;

    function automatic logic [LZC_W-1:0] count_lz(input logic [DW-1:0] v);
        logic [LZC_W-1:0] n;
        logic             hit;
        n   = '0;
        hit = 1'b0;
        for (int i = DW - 1; i >= 0; i--) begin
            if (!hit) begin
                if (v[i]) hit = 1'b1;
                else      n   = n + 1'b1;
            end
        end
        return n;
    endfunction

    assign s2_adv   = !out_valid || out_ready;
    assign s1_adv   = !s1_valid || s2_adv;
    assign in_ready = s1_adv;

    // Resolve effective operation; subtract always yields a magnitude.
    always_comb begin
        eff_sub = ma_sign ^ mb_sign ^ operation_select;
        a_ge_b  = man_a >= man_b;
        sum     = {1'b0, man_a} + {1'b0, man_b};
        r_d     = sum[DW-1:0];
        c_d     = sum[DW];
        sign_d  = ma_sign;
        if (eff_sub) begin
            c_d = 1'b0;
            if (a_ge_b) begin
                r_d    = man_a - man_b;
                sign_d = ma_sign;
            end else begin
                r_d    = man_b - man_a;
                sign_d = mb_sign ^ operation_select;
            end
            if (r_d == '0) sign_d = 1'b0;
        end
    end

    // Stage 1 register: captures on input accept.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            s1_valid <= 1'b0;
            s1_r     <= '0;
            s1_c     <= 1'b0;
            s1_sign  <= 1'b0;
        end else if (s1_adv) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_r    <= r_d;
                s1_c    <= c_d;
                s1_sign <= sign_d;
            end
        end
    end

    // Leading zeros; a carry means the MSB sits above bit DW-1.
    always_comb begin
        zero_d = !s1_c && (s1_r == '0);
        lzc_d  = count_lz(s1_r);
        if (s1_c)        lzc_d = '0;
        else if (zero_d) lzc_d = LZC_W'(DW);
    end

    // Stage 2 register: output side, holds while stalled.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            out_valid   <= 1'b0;
            result      <= '0;
            carry_out   <= 1'b0;
            result_sign <= 1'b0;
            lzc         <= '0;
            zero_result <= 1'b0;
        end else if (s2_adv) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                result      <= s1_r;
                carry_out   <= s1_c;
                result_sign <= s1_sign;
                lzc         <= lzc_d;
                zero_result <= zero_d;
            end
        end
    end

endmodule
